// File: rtl/fre_measure_auto.sv
// Reciprocal frequency meter: one gate/counter engine shared by a direct and a
// 2^DIV_LOG2-prescaled input path, with hysteretic auto-ranging and input timeout.
module fre_measure_auto #(
  parameter int unsigned W              = 32,
  parameter int unsigned GATE_CYCLES    = 100_000_000,
  parameter int unsigned DIV_LOG2       = 5,
  parameter int unsigned UP_THRESH      = 25_000_000,
  parameter int unsigned DN_THRESH      = 625_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
  input  logic         clk_100M,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] M_out,
  output logic [W-1:0] N_out,
  output logic         range_div,
  output logic         valid,
  output logic         timeout,
  output logic         sig_out,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_GATE  = 2'd1,
    ST_CLOSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_LOG2-1:0]   r_pre_cnt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic [W-1:0]          r_m;
  logic [W-1:0]          r_n;
  logic [W-1:0]          r_soft;
  logic [W-1:0]          r_wait;
  logic [W-1:0]          r_m_out;
  logic [W-1:0]          r_n_out;
  logic                  r_range_div;
  logic                  r_discard;
  logic                  r_valid;
  logic                  r_timeout;

  logic                  w_src;
  logic                  w_rise;
  logic                  w_gate_hit;
  logic                  w_wait_hit;
  logic                  w_open;
  logic                  w_close;
  logic                  w_tmo;
  logic                  w_done;
  logic                  w_go_div;
  logic                  w_go_dir;
  logic                  w_range_chg;
  logic [W-1:0]          w_n_inc;
  logic [W+DIV_LOG2-1:0] w_n_wide;
  logic [W-1:0]          w_n_scaled;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Prescaler lives in the sig_in domain; its MSB is a 50% duty divided clock.
  always_ff @(posedge sig_in or posedge rst) begin
    if (rst) r_pre_cnt <= '0;
    else     r_pre_cnt <= r_pre_cnt + 1'b1;
  end

  assign w_src      = r_range_div ? r_pre_cnt[DIV_LOG2-1] : sig_in;
  assign w_rise     = r_sync2 & ~r_prev;
  assign w_gate_hit = (r_soft == W'(GATE_CYCLES));
  assign w_wait_hit = (r_wait == W'(TIMEOUT_CYCLES - 1));
  assign w_n_inc    = sat_inc(r_n);
  assign w_n_wide   = {{DIV_LOG2{1'b0}}, w_n_inc} << DIV_LOG2;
  assign w_n_scaled = r_range_div ? ((|w_n_wide[W+DIV_LOG2-1:W]) ? '1 : w_n_wide[W-1:0])
                                  : w_n_inc;

  assign w_go_div    = ~r_range_div & (r_n > W'(UP_THRESH));
  assign w_go_dir    =  r_range_div & (r_n < W'(DN_THRESH));
  assign w_range_chg = (w_done & (w_go_div | w_go_dir)) | (w_tmo & r_range_div);

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) r_state <= ST_ARM;
    else     r_state <= w_state_nxt;
  end

  // A rise always beats a coincident timeout; the gate end never closes on its own.
  always_comb begin
    w_state_nxt = r_state;
    w_open      = 1'b0;
    w_close     = 1'b0;
    w_tmo       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (w_rise) begin
          w_open      = 1'b1;
          w_state_nxt = ST_GATE;
        end else if (w_wait_hit) begin
          w_tmo = 1'b1;
        end
      end
      ST_GATE: begin
        if (w_gate_hit) w_state_nxt = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (w_rise) begin
          w_close     = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_wait_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      default: begin
        w_done      = 1'b1;
        w_state_nxt = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_m         <= '0;
      r_n         <= '0;
      r_soft      <= '0;
      r_wait      <= '0;
      r_m_out     <= '0;
      r_n_out     <= '0;
      r_range_div <= 1'b0;
      r_discard   <= 1'b0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // On a source switch the chain is loaded high so only a genuine low-to-high
      // transition of the new source can produce the next rise.
      if (w_range_chg) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_prev  <= 1'b1;
      end else begin
        r_sync1 <= w_src;
        r_sync2 <= r_sync1;
        r_prev  <= r_sync2;
      end

      r_valid <= 1'b0;
      case (r_state)
        ST_ARM: begin
          if (w_open) begin
            r_m    <= W'(1);
            r_n    <= '0;
            r_soft <= W'(1);
            r_wait <= '0;
          end else begin
            r_wait <= w_tmo ? '0 : r_wait + 1'b1;
          end
        end
        ST_GATE: begin
          r_m    <= sat_inc(r_m);
          r_soft <= r_soft + 1'b1;
          if (w_rise) r_n <= w_n_inc;
        end
        ST_CLOSE: begin
          if (w_rise) begin
            r_n    <= w_n_inc;
            r_wait <= '0;
          end else begin
            r_m    <= sat_inc(r_m);
            r_wait <= w_tmo ? '0 : r_wait + 1'b1;
          end
        end
        default: ;
      endcase

      // valid is a one-cycle strobe with no ready; results hold until the next strobe.
      if (w_close && !r_discard) begin
        r_m_out   <= r_m;
        r_n_out   <= w_n_scaled;
        r_valid   <= 1'b1;
        r_timeout <= 1'b0;
      end

      if (w_tmo) begin
        r_m_out     <= '0;
        r_n_out     <= '0;
        r_valid     <= 1'b1;
        r_timeout   <= 1'b1;
        r_range_div <= 1'b0;
        r_discard   <= 1'b0;
      end

      if (w_done) begin
        r_discard <= w_go_div | w_go_dir;
        if (w_go_div)      r_range_div <= 1'b1;
        else if (w_go_dir) r_range_div <= 1'b0;
      end
    end
  end

  assign M_out     = r_m_out;
  assign N_out     = r_n_out;
  assign range_div = r_range_div;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign sig_out   = r_sync2;
  assign dbg_state = r_state;

endmodule
